// File: rtl/alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : alu_op_sequencer                                             |
// | Description : Board-input controller for the 32-bit ALU. Synchronises and  |
// |               debounces the load-A / load-B / execute buttons, latches the |
// |               operands from the switches, issues the op code and captures  |
// |               the ALU result and flags for the display path.               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module alu_op_sequencer #(
    parameter int DB_CNT   = 1000000,  // cycles a button level must be stable
    parameter int DB_W     = 20,       // debounce counter width, 2**DB_W > DB_CNT
    parameter int EXEC_LAT = 1         // cycles from operands valid to result sample
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] sw,
    input  logic        btn_a,
    input  logic        btn_b,
    input  logic        btn_f,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_op,
    input  logic [31:0] alu_res,
    input  logic [3:0]  alu_flg,
    output logic [31:0] result,
    output logic [3:0]  flags,
    output logic [2:0]  state,
    output logic        busy,
    output logic        done
);

    // State encoding is visible on the debug LEDs, so the codes are fixed.
    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_GOT_A = 3'd1;
    localparam logic [2:0] c_GOT_B = 3'd2;
    localparam logic [2:0] c_EXEC  = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    localparam int              c_LAT_W    = (EXEC_LAT > 1) ? $clog2(EXEC_LAT) : 1;
    localparam logic [c_LAT_W-1:0] c_LAT_LAST = c_LAT_W'(EXEC_LAT - 1);
    localparam logic [DB_W-1:0] c_DB_LAST  = DB_W'(DB_CNT - 1);

    // Bit 0 = load A, bit 1 = load B, bit 2 = execute.
    logic [2:0] w_btn_raw;
    logic [2:0] w_pulse;

    assign w_btn_raw = {btn_f, btn_b, btn_a};

    // One conditioning chain per button: sync -> debounce -> rising-edge pulse.
    for (genvar gi = 0; gi < 3; gi++) begin : g_btn
        logic            r_sync1;
        logic            r_sync2;
        logic            r_lvl;
        logic            r_lvl_d;
        logic [DB_W-1:0] r_cnt;

        // Two-flop synchroniser, then a stability counter that only runs while
        // the synced level disagrees with the accepted level; any agreement
        // (i.e. a bounce back) clears it, so only a steady change is accepted.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1 <= 1'b0;
                r_sync2 <= 1'b0;
                r_lvl   <= 1'b0;
                r_lvl_d <= 1'b0;
                r_cnt   <= '0;
            end else begin
                r_sync1 <= w_btn_raw[gi];
                r_sync2 <= r_sync1;
                r_lvl_d <= r_lvl;
                if (r_sync2 == r_lvl) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_DB_LAST) begin
                    // Accept the new level; counter returns to 0 instead of wrapping.
                    r_lvl <= r_sync2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + DB_W'(1);
                end
            end
        end

        // Press edge only; release produces no pulse.
        assign w_pulse[gi] = r_lvl & ~r_lvl_d;
    end

    // Same-cycle pulses resolve as A over B over F; losers are dropped.
    logic w_act_a;
    logic w_act_b;
    logic w_act_f;

    assign w_act_a = w_pulse[0];
    assign w_act_b = w_pulse[1] & ~w_pulse[0];
    assign w_act_f = w_pulse[2] & ~w_pulse[1] & ~w_pulse[0];

    logic [2:0]         r_state;
    logic [31:0]        r_alu_a;
    logic [31:0]        r_alu_b;
    logic [2:0]         r_alu_op;
    logic [31:0]        r_result;
    logic [3:0]         r_flags;
    logic               r_done;
    logic [c_LAT_W-1:0] r_lat_cnt;

    // Sequencing FSM: operand loads, op issue, and result/flag capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_IDLE;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= '0;
            r_result  <= '0;
            r_flags   <= '0;
            r_done    <= 1'b0;
            r_lat_cnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_act_a) begin
                        r_alu_a <= sw;
                        r_state <= c_GOT_A;
                    end
                end
                c_GOT_A: begin
                    if (w_act_a) begin
                        r_alu_a <= sw;
                    end else if (w_act_b) begin
                        r_alu_b <= sw;
                        r_state <= c_GOT_B;
                    end
                end
                c_GOT_B: begin
                    if (w_act_a) begin
                        r_alu_a <= sw;
                        r_state <= c_GOT_A;
                    end else if (w_act_b) begin
                        r_alu_b <= sw;
                    end else if (w_act_f) begin
                        r_alu_op  <= sw[2:0];
                        r_lat_cnt <= '0;
                        r_state   <= c_EXEC;
                    end
                end
                c_EXEC: begin
                    // Operands and op are frozen here; buttons are ignored.
                    if (r_lat_cnt == c_LAT_LAST) begin
                        r_result <= alu_res;
                        r_flags  <= alu_flg;
                        r_done   <= 1'b1;
                        r_state  <= c_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_LAT_W'(1);
                    end
                end
                c_DONE: begin
                    if (w_act_a) begin
                        r_alu_a <= sw;
                        r_state <= c_GOT_A;
                    end else if (w_act_b) begin
                        r_alu_b <= sw;
                        r_state <= c_GOT_B;
                    end else if (w_act_f) begin
                        // Re-run with the held operands and a fresh op code.
                        r_alu_op  <= sw[2:0];
                        r_lat_cnt <= '0;
                        r_state   <= c_EXEC;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign alu_a  = r_alu_a;
    assign alu_b  = r_alu_b;
    assign alu_op = r_alu_op;
    assign result = r_result;
    assign flags  = r_flags;
    assign state  = r_state;
    assign busy   = (r_state == c_EXEC);
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_alu_op_sequencer                                          |
// | Description : Directed bench for alu_op_sequencer with a behavioural ALU   |
// |               and a result/flag scoreboard fed by the stimulus process.    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic [31:0] sw;
    logic        btn_a;
    logic        btn_b;
    logic        btn_f;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_res;
    logic [3:0]  alu_flg;
    logic [31:0] result;
    logic [3:0]  flags;
    logic [2:0]  state;
    logic        busy;
    logic        done;

    int n_cmp  = 0;
    int n_err  = 0;
    int n_done = 0;

    // Expected {flags, result} per execution, oldest first.
    logic [35:0] exp_q[$];

    alu_op_sequencer #(
        .DB_CNT   (4),
        .DB_W     (3),
        .EXEC_LAT (1)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .sw      (sw),
        .btn_a   (btn_a),
        .btn_b   (btn_b),
        .btn_f   (btn_f),
        .alu_a   (alu_a),
        .alu_b   (alu_b),
        .alu_op  (alu_op),
        .alu_res (alu_res),
        .alu_flg (alu_flg),
        .result  (result),
        .flags   (flags),
        .state   (state),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: flags are {ZF, SF, CF, OF}; CF/OF only meaningful for add.
    logic [32:0] m_sum;
    logic        m_c;
    logic        m_o;
    always_comb begin
        m_sum   = {1'b0, alu_a} + {1'b0, alu_b};
        alu_res = '0;
        m_c     = 1'b0;
        m_o     = 1'b0;
        case (alu_op)
            3'd0: begin
                alu_res = m_sum[31:0];
                m_c     = m_sum[32];
                m_o     = (alu_a[31] == alu_b[31]) && (m_sum[31] != alu_a[31]);
            end
            3'd1:    alu_res = alu_a << alu_b[4:0];
            3'd2:    alu_res = {31'd0, ($signed(alu_a) < $signed(alu_b))};
            3'd3:    alu_res = alu_a - alu_b;
            3'd4:    alu_res = alu_a & alu_b;
            3'd5:    alu_res = alu_a | alu_b;
            3'd6:    alu_res = alu_a ^ alu_b;
            default: alu_res = ~(alu_a | alu_b);
        endcase
        alu_flg = {(alu_res == 32'd0), alu_res[31], m_c, m_o};
    end

    // Monitor: every done pulse must match the oldest expected capture.
    always @(negedge clk) begin
        if (rst_n && done) begin
            n_done++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_done: result=%h flags=%h with no pending op", result, flags);
            end else begin
                logic [35:0] e;
                e = exp_q.pop_front();
                if ({flags, result} !== e) begin
                    n_err++;
                    $display("FAIL capture: got flags=%h result=%h, expected flags=%h result=%h",
                             flags, result, e[35:32], e[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Hold a button long enough to clear sync + debounce, then release cleanly.
    task automatic press(input int which, input logic [31:0] val);
        sw = val;
        case (which)
            0:       btn_a = 1'b1;
            1:       btn_b = 1'b1;
            default: btn_f = 1'b1;
        endcase
        repeat (12) @(posedge clk);
        #1;
        btn_a = 1'b0;
        btn_b = 1'b0;
        btn_f = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        sw    = '0;
        btn_a = 1'b0;
        btn_b = 1'b0;
        btn_f = 1'b0;
        #1;
        check("reset_state",  {29'd0, state}, 32'd0);
        check("reset_alu_a",  alu_a, 32'd0);
        check("reset_result", result, 32'd0);
        check("reset_flags",  {28'd0, flags}, 32'd0);
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Execute in IDLE is ignored.
        press(2, 32'd1);
        check("pf_in_idle_state", {29'd0, state}, 32'd0);
        check("pf_in_idle_op",    {29'd0, alu_op}, 32'd0);

        // A and B rise together: only A is taken.
        sw    = 32'h0000_0055;
        btn_a = 1'b1;
        btn_b = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        btn_a = 1'b0;
        btn_b = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("prio_state", {29'd0, state}, 32'd1);
        check("prio_alu_a", alu_a, 32'h0000_0055);
        check("prio_alu_b", alu_b, 32'd0);

        // Bouncing A button: no load while it chatters.
        sw = 32'h0000_1234;
        for (int i = 0; i < 10; i++) begin
            btn_a = ~btn_a;
            repeat (2) @(posedge clk);
            #1;
            check("bounce_hold_a", alu_a, 32'h0000_0055);
        end
        repeat (6) @(posedge clk);
        #1;
        check("bounce_after_a", alu_a, 32'h0000_0055);
        btn_a = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        btn_a = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("bounce_load_a", alu_a, 32'h0000_1234);
        check("bounce_state",  {29'd0, state}, 32'd1);

        // Add with carry out: FFFFFFFF + FFFFFFFF.
        press(0, 32'hFFFF_FFFF);
        press(1, 32'hFFFF_FFFF);
        check("add_got_b", {29'd0, state}, 32'd2);
        exp_q.push_back({4'b0110, 32'hFFFF_FFFE});
        press(2, 32'd0);
        check("add_state", {29'd0, state}, 32'd4);

        // Shift left: 1 << 2.
        press(0, 32'h0000_0001);
        check("done_pa_state", {29'd0, state}, 32'd1);
        press(1, 32'h0000_0002);
        exp_q.push_back({4'b0000, 32'h0000_0004});
        press(2, 32'd1);
        check("sll_state", {29'd0, state}, 32'd4);
        check("sll_op",    {29'd0, alu_op}, 32'd1);

        // Signed less-than, negative A.
        press(0, 32'hA000_0001);
        press(1, 32'h0000_0001);
        exp_q.push_back({4'b0000, 32'h0000_0001});
        press(2, 32'd2);
        // Signed less-than, false case (zero flag set).
        press(0, 32'h0000_0002);
        press(1, 32'h0000_0001);
        exp_q.push_back({4'b1000, 32'h0000_0000});
        press(2, 32'd2);
        check("slt_op", {29'd0, alu_op}, 32'd2);

        // Re-execute from DONE with held operands: 2 + 1.
        exp_q.push_back({4'b0000, 32'h0000_0003});
        press(2, 32'd0);
        check("reexec_state", {29'd0, state}, 32'd4);
        check("reexec_alu_a", alu_a, 32'h0000_0002);

        // Reset while executing: nothing captured, everything cleared.
        sw    = 32'd1;
        btn_f = 1'b1;
        begin
            bit seen;
            seen = 1'b0;
            for (int i = 0; i < 30 && !seen; i++) begin
                @(posedge clk);
                #1;
                if (busy) seen = 1'b1;
            end
            check("exec_reached", {31'd0, seen}, 32'd1);
        end
        rst_n = 1'b0;
        #1;
        check("rst_exec_state",  {29'd0, state}, 32'd0);
        check("rst_exec_result", result, 32'd0);
        check("rst_exec_flags",  {28'd0, flags}, 32'd0);
        check("rst_exec_ops",    alu_a | alu_b | {29'd0, alu_op}, 32'd0);
        check("rst_exec_busy_done", {30'd0, busy, done}, 32'd0);
        btn_f = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_state",  {29'd0, state}, 32'd0);
        check("post_rst_result", result, 32'd0);

        check("pending_ops", exp_q.size(), 32'd0);
        check("done_count",  n_done, 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
